// File: rtl/bp_me_pkg.sv
// Shared types for the hybrid CCE mode-transition controller: config-bus and
// LCE command header layouts, the controller state enum and the drain predicate.
package bp_me_pkg;

    localparam int num_lce_gp      = 8;
    localparam int cce_id_width_gp = 3;
    localparam int lce_id_width_gp = 4;

    typedef enum logic [0:0] {
        e_cce_mode_uncached = 1'b0,
        e_cce_mode_normal   = 1'b1
    } bp_cce_mode_e;

    typedef enum logic [3:0] {
        e_bedrock_cmd_sync      = 4'b0000,
        e_bedrock_cmd_set_clear = 4'b0001,
        e_bedrock_cmd_inv       = 4'b0010,
        e_bedrock_cmd_st        = 4'b0011
    } bp_bedrock_cmd_type_e;

    // Only the fields this controller consumes are carried on the config bus.
    typedef struct packed {
        logic [cce_id_width_gp-1:0] cce_id;
        bp_cce_mode_e               cce_mode;
    } bp_cfg_bus_s;

    localparam int cfg_bus_width_gp = $bits(bp_cfg_bus_s);

    typedef struct packed {
        logic [cce_id_width_gp-1:0] src_id;
        logic [lce_id_width_gp-1:0] dst_id;
        bp_bedrock_cmd_type_e       msg_type;
    } bp_lce_cmd_header_s;

    localparam int lce_cmd_header_width_gp = $bits(bp_lce_cmd_header_s);

    typedef enum logic [2:0] {
        e_ready,
        e_wait_drain,
        e_send_sync,
        e_wait_ack,
        e_commit
    } bp_cce_hybrid_sync_state_e;

    // Pipes are quiescent only once the stall request is actually in effect.
    function automatic logic drain_complete(input logic stall,
                                            input logic req_empty,
                                            input logic uc_empty,
                                            input logic coh_empty,
                                            input logic credits_full);
        return stall & req_empty & uc_empty & coh_empty & credits_full;
    endfunction

endpackage

// File: rtl/bp_cce_sync_mask_walker.sv
// Walks the captured LCE sync mask from the lowest set bit upward, one LCE per
// advance. Sent bits are cleared, so the next pointer is simply the lowest
// remaining bit.
module bp_cce_sync_mask_walker
    #(parameter  int num_lce_p    = 8,
      localparam int ptr_width_lp = (num_lce_p > 1) ? $clog2(num_lce_p) : 1)
    (input  logic                    clk_i,
     input  logic                    reset_n_i,
     input  logic                    load_i,
     input  logic [num_lce_p-1:0]    mask_i,
     input  logic                    adv_i,
     output logic                    v_o,
     output logic [ptr_width_lp-1:0] dst_o,
     output logic                    last_o);

    logic [num_lce_p-1:0]    mask_q, mask_d, remain, scan;
    logic [ptr_width_lp-1:0] ptr_q, ptr_d, lowest;

    // Bits still owed a sync once the LCE under the pointer has been served.
    for (genvar gi = 0; gi < num_lce_p; gi++) begin : g_remain
        assign remain[gi] = mask_q[gi] & (ptr_q != ptr_width_lp'(gi));
    end

    // Priority-encode the lowest set bit of either the fresh or remaining mask.
    always_comb begin
        scan   = load_i ? mask_i : remain;
        lowest = '0;
        for (int i = num_lce_p - 1; i >= 0; i--) begin
            if (scan[i]) lowest = ptr_width_lp'(i);
        end
    end

    // Load a new mask or step past the LCE just served.
    always_comb begin
        mask_d = mask_q;
        ptr_d  = ptr_q;
        if (load_i) begin
            mask_d = mask_i;
            ptr_d  = lowest;
        end else if (adv_i) begin
            mask_d = remain;
            ptr_d  = lowest;
        end
    end

    // Mask and pointer registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mask_q <= '0;
            ptr_q  <= '0;
        end else begin
            mask_q <= mask_d;
            ptr_q  <= ptr_d;
        end
    end

    assign v_o    = |mask_q;
    assign dst_o  = ptr_q;
    assign last_o = ~|remain;

endmodule

// File: rtl/bp_cce_hybrid_sync_ctrl.sv
// Hybrid CCE mode-transition controller: drains the CCE pipes, syncs a
// selectable set of LCEs with a bounded window of outstanding syncs, then
// commits the new mode. Define BP_CCE_SYNC_TIMEOUT_EN to add a sticky
// watchdog (sync_error_o) on sync progress.
module bp_cce_hybrid_sync_ctrl
    import bp_me_pkg::*;
    #(parameter  int num_lce_p         = num_lce_gp,
      parameter  int lce_data_width_p  = 64,
      parameter  int sync_window_p     = 4,
      parameter  int timeout_cycles_p  = 4096,
      localparam int cfg_bus_width_lp  = cfg_bus_width_gp,
      localparam int lce_cmd_msg_header_width_lp = lce_cmd_header_width_gp,
      localparam int cnt_width_lp      = $clog2(num_lce_p + 1),
      localparam int ptr_width_lp      = (num_lce_p > 1) ? $clog2(num_lce_p) : 1)
    (input  logic                                   clk_i,
     input  logic                                   reset_n_i,
     input  logic [cfg_bus_width_lp-1:0]            cfg_bus_i,
     input  logic [num_lce_p-1:0]                   sync_mask_i,
     output logic [lce_cmd_msg_header_width_lp-1:0] lce_cmd_header_o,
     output logic                                   lce_cmd_header_v_o,
     input  logic                                   lce_cmd_header_ready_and_i,
     output logic                                   lce_cmd_has_data_o,
     output logic [lce_data_width_p-1:0]            lce_cmd_data_o,
     output logic                                   lce_cmd_data_v_o,
     output logic                                   lce_cmd_last_o,
     input  logic                                   lce_cmd_data_ready_and_i,
     input  logic                                   sync_yumi_i,
     output logic                                   cce_mode_o,
     output logic [cce_id_width_gp-1:0]             cce_id_o,
     output logic                                   drain_then_stall_o,
     output logic                                   busy_o,
     input  logic                                   req_empty_i,
     input  logic                                   uc_pipe_empty_i,
     input  logic                                   coh_pipe_empty_i,
     input  logic                                   mem_credits_full_i
`ifdef BP_CCE_SYNC_TIMEOUT_EN
     , output logic                                 sync_error_o
`endif
    );

    if (sync_window_p < 1 || sync_window_p > num_lce_p) begin : g_bad_window
        $error("sync_window_p must lie in 1..num_lce_p");
    end
    if (timeout_cycles_p < 1) begin : g_bad_timeout
        $error("timeout_cycles_p must be positive");
    end

    bp_cfg_bus_s               cfg;
    bp_lce_cmd_header_s        hdr;
    bp_cce_hybrid_sync_state_e state_q, state_d;
    bp_cce_mode_e              mode_q, mode_d, tgt_q, tgt_d;
    logic                      stall_q, stall_d;
    logic [cnt_width_lp-1:0]   sent_q, sent_d, acked_q, acked_d, outstanding;
    logic                      load, clear_cnt, hdr_v, hs;
    logic                      walk_v, walk_last;
    logic [ptr_width_lp-1:0]   walk_dst;
    logic                      unused_data_ready;

    assign cfg               = cfg_bus_i;
    assign unused_data_ready = lce_cmd_data_ready_and_i;
    assign outstanding       = sent_q - acked_q;
    assign hs                = hdr_v & lce_cmd_header_ready_and_i;

    bp_cce_sync_mask_walker #(.num_lce_p(num_lce_p)) walker (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .load_i    (load),
        .mask_i    (sync_mask_i),
        .adv_i     (hs),
        .v_o       (walk_v),
        .dst_o     (walk_dst),
        .last_o    (walk_last)
    );

    // Next-state, stall and commit decisions for the transition sequence.
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        stall_d   = stall_q;
        mode_d    = mode_q;
        load      = 1'b0;
        clear_cnt = 1'b0;
        hdr_v     = 1'b0;
        unique case (state_q)
            e_ready: begin
                if (cfg.cce_mode != mode_q) begin
                    state_d = e_wait_drain;
                    stall_d = 1'b1;
                    tgt_d   = cfg.cce_mode;
                end
            end
            e_wait_drain: begin
                if (drain_complete(stall_q, req_empty_i, uc_pipe_empty_i,
                                   coh_pipe_empty_i, mem_credits_full_i)) begin
                    // The request may have moved while draining; latest wins.
                    tgt_d = cfg.cce_mode;
                    if (cfg.cce_mode == e_cce_mode_uncached) begin
                        state_d = e_commit;
                    end else begin
                        load      = 1'b1;
                        clear_cnt = 1'b1;
                        state_d   = (|sync_mask_i) ? e_send_sync : e_commit;
                    end
                end
            end
            e_send_sync: begin
                hdr_v = walk_v & (outstanding < cnt_width_lp'(sync_window_p));
                if (hdr_v & lce_cmd_header_ready_and_i & walk_last) state_d = e_wait_ack;
            end
            e_wait_ack: begin
                if (acked_q == sent_q) state_d = e_commit;
            end
            e_commit: begin
                if (cfg.cce_mode == tgt_q) begin
                    mode_d  = tgt_q;
                    stall_d = 1'b0;
                    state_d = e_ready;
                end else begin
                    // Pipes are still stalled, so the redrain finishes at once.
                    state_d = e_wait_drain;
                end
            end
            default: state_d = e_ready;
        endcase
    end

    // Sent/acked counters; acks are counted in every state.
    always_comb begin
        sent_d  = clear_cnt ? '0 : sent_q + cnt_width_lp'(hs);
        acked_d = clear_cnt ? cnt_width_lp'(sync_yumi_i)
                            : acked_q + cnt_width_lp'(sync_yumi_i);
    end

    // Controller state, committed mode and counter registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_ready;
            mode_q  <= e_cce_mode_uncached;
            tgt_q   <= e_cce_mode_uncached;
            stall_q <= 1'b0;
            sent_q  <= '0;
            acked_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            tgt_q   <= tgt_d;
            stall_q <= stall_d;
            sent_q  <= sent_d;
            acked_q <= acked_d;
        end
    end

    // Header fields for the sync command to the LCE under the walker pointer.
    always_comb begin
        hdr          = '0;
        hdr.msg_type = e_bedrock_cmd_sync;
        hdr.src_id   = cfg.cce_id;
        hdr.dst_id   = lce_id_width_gp'(walk_dst);
    end

    assign lce_cmd_header_o   = hdr;
    assign lce_cmd_header_v_o = hdr_v;
    assign lce_cmd_has_data_o = 1'b0;
    assign lce_cmd_data_o     = '0;
    assign lce_cmd_data_v_o   = 1'b0;
    assign lce_cmd_last_o     = 1'b0;
    assign cce_mode_o         = mode_q;
    assign cce_id_o           = cfg.cce_id;
    assign drain_then_stall_o = stall_q;
    assign busy_o             = (state_q != e_ready);

    // An ack can only answer a sync sent during the current transition.
    ack_outside_sync_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(sync_yumi_i && (state_q == e_ready || state_q == e_wait_drain)));

`ifdef BP_CCE_SYNC_TIMEOUT_EN
    localparam int tmo_width_lp = $clog2(timeout_cycles_p + 1);

    logic [tmo_width_lp-1:0] tmo_q, tmo_d;
    logic                    err_q, err_d, waiting;

    assign waiting = (state_q == e_send_sync) || (state_q == e_wait_ack);

    // Count cycles without sync progress; saturate and latch the error.
    always_comb begin
        tmo_d = tmo_q;
        err_d = err_q;
        if (hs | sync_yumi_i | ~waiting) begin
            tmo_d = '0;
        end else if (tmo_q != tmo_width_lp'(timeout_cycles_p)) begin
            tmo_d = tmo_q + tmo_width_lp'(1);
            if (tmo_d == tmo_width_lp'(timeout_cycles_p)) err_d = 1'b1;
        end
    end

    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign sync_error_o = err_q;
`endif

endmodule

// File: tb/tb_bp_cce_hybrid_sync_ctrl.sv
module tb_bp_cce_hybrid_sync_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        cfg_mode;
    logic [2:0]  cfg_id;
    logic [3:0]  cfg_bus;
    logic [7:0]  sync_mask;
    logic [10:0] hdr;
    logic        hdr_v, hdr_ready;
    logic        has_data, data_v, data_last;
    logic [63:0] data;
    logic        sync_yumi;
    logic        cce_mode_o;
    logic [2:0]  cce_id_o;
    logic        stall, busy;
    logic        req_empty, uc_empty, coh_empty, credits_full;
    logic        sync_error;

    assign cfg_bus = {cfg_id, cfg_mode};

    bp_cce_hybrid_sync_ctrl #(
        .num_lce_p(8), .lce_data_width_p(64), .sync_window_p(4), .timeout_cycles_p(16)
    ) dut (
        .clk_i                      (clk),
        .reset_n_i                  (reset_n),
        .cfg_bus_i                  (cfg_bus),
        .sync_mask_i                (sync_mask),
        .lce_cmd_header_o           (hdr),
        .lce_cmd_header_v_o         (hdr_v),
        .lce_cmd_header_ready_and_i (hdr_ready),
        .lce_cmd_has_data_o         (has_data),
        .lce_cmd_data_o             (data),
        .lce_cmd_data_v_o           (data_v),
        .lce_cmd_last_o             (data_last),
        .lce_cmd_data_ready_and_i   (1'b1),
        .sync_yumi_i                (sync_yumi),
        .cce_mode_o                 (cce_mode_o),
        .cce_id_o                   (cce_id_o),
        .drain_then_stall_o         (stall),
        .busy_o                     (busy),
        .req_empty_i                (req_empty),
        .uc_pipe_empty_i            (uc_empty),
        .coh_pipe_empty_i           (coh_empty),
        .mem_credits_full_i         (credits_full)
`ifdef BP_CCE_SYNC_TIMEOUT_EN
        , .sync_error_o             (sync_error)
`endif
    );

`ifndef BP_CCE_SYNC_TIMEOUT_EN
    assign sync_error = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Model: destinations still owed a sync, plus sync/ack totals.
    int   exp_q[$];
    int   m_sent = 0;
    int   m_acked = 0;
    bit   ack_en = 0;
    bit   forbid_normal = 0;
    logic        prev_v = 1'b0, prev_ready = 1'b0;
    logic [10:0] prev_hdr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Request a mode; a normal target owes one sync per set mask bit, lowest first.
    task automatic start_mode(input logic mode, input logic [7:0] mask);
        sync_mask = mask;
        cfg_mode  = mode;
        if (mode) begin
            for (int i = 0; i < 8; i++) if (mask[i]) exp_q.push_back(i);
        end
        $display("txn: request mode=%0d mask=%08b", mode, mask);
    endtask

    task automatic wait_release(input string name, output int cycles);
        cycles = 0;
        do begin
            cyc(1);
            cycles++;
        end while (stall && cycles < 400);
        check({name, "_released"}, {31'd0, stall}, 32'd0);
    endtask

    // LCE stand-in: acks one outstanding sync per cycle when enabled.
    initial begin
        sync_yumi = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            sync_yumi = ack_en && (m_sent > m_acked) && reset_n;
        end
    end

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            check("const_zero", {31'd0, has_data | data_v | data_last | (|data)}, 32'd0);
            check("cce_id", {29'd0, cce_id_o}, {29'd0, cfg_id});
            if (forbid_normal) check("mode_never_normal", {31'd0, cce_mode_o}, 32'd0);
            if (prev_v && !prev_ready) begin
                check("bp_v_held", {31'd0, hdr_v}, 32'd1);
                check("bp_hdr_stable", {21'd0, hdr}, {21'd0, prev_hdr});
            end
            if (hdr_v) begin
                check("v_while_stalled", {31'd0, stall}, 32'd1);
                check("window_respected", ((m_sent - m_acked) < 4) ? 32'd1 : 32'd0, 32'd1);
                check("sync_owed", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_q.size() > 0)
                    check("sync_header", {21'd0, hdr},
                          {21'd0, cfg_id, 4'(exp_q[0]), 4'h0});
            end
            if (hdr_v && hdr_ready) begin
                $display("txn: sync sent dst=%0d", hdr[7:4]);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                m_sent++;
            end
            if (sync_yumi) m_acked++;
            prev_v     = hdr_v;
            prev_ready = hdr_ready;
            prev_hdr   = hdr;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    int n, bs, ba;

    initial begin
        reset_n = 1'b0; cfg_mode = 1'b0; cfg_id = 3'd5; sync_mask = '0; hdr_ready = 1'b1;
        req_empty = 1'b1; uc_empty = 1'b1; coh_empty = 1'b1; credits_full = 1'b1;
        cyc(3);
        check("rst_mode", {31'd0, cce_mode_o}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_v", {31'd0, hdr_v}, 32'd0);
        check("rst_err", {31'd0, sync_error}, 32'd0);
        reset_n = 1'b1;
        cyc(2);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Full mask, window of 4, no acks yet: exactly 4 syncs then a stall.
        start_mode(1'b1, 8'hFF);
        cyc(12);
        check("t1_window_sent", m_sent, 32'd4);
        check("t1_v_blocked", {31'd0, hdr_v}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_mode_held", {31'd0, cce_mode_o}, 32'd0);
        ack_en = 1;
        wait_release("t1", n);
        check("t1_sent_total", m_sent, 32'd8);
        check("t1_acked_total", m_acked, 32'd8);
        check("t1_mode", {31'd0, cce_mode_o}, 32'd1);
        check("t1_busy_after", {31'd0, busy}, 32'd0);
        check("t1_q_empty", exp_q.size(), 32'd0);

        // Minimum uncached transition: release 3 cycles after the request.
        start_mode(1'b0, 8'h00);
        cyc(1);
        check("t2u_stall_c1", {31'd0, stall}, 32'd1);
        check("t2u_mode_c1", {31'd0, cce_mode_o}, 32'd1);
        cyc(1);
        check("t2u_stall_c2", {31'd0, stall}, 32'd1);
        check("t2u_mode_c2", {31'd0, cce_mode_o}, 32'd1);
        cyc(1);
        check("t2u_stall_c3", {31'd0, stall}, 32'd0);
        check("t2u_mode_c3", {31'd0, cce_mode_o}, 32'd0);
        check("t2u_busy_c3", {31'd0, busy}, 32'd0);

        // Sparse mask: syncs to 2, 5, 7 only.
        bs = m_sent; ba = m_acked;
        start_mode(1'b1, 8'hA4);
        wait_release("t2", n);
        check("t2_sent", m_sent - bs, 32'd3);
        check("t2_acked", m_acked - ba, 32'd3);
        check("t2_mode", {31'd0, cce_mode_o}, 32'd1);
        check("t2_q_empty", exp_q.size(), 32'd0);

        // Pipes not empty: the stall holds and the mode does not move.
        req_empty = 1'b0;
        start_mode(1'b0, 8'h00);
        cyc(6);
        check("t3_stall_hold", {31'd0, stall}, 32'd1);
        check("t3_busy_hold", {31'd0, busy}, 32'd1);
        check("t3_mode_hold", {31'd0, cce_mode_o}, 32'd1);
        req_empty = 1'b1;
        wait_release("t3u", n);
        check("t3u_release_cycles", n, 32'd2);
        check("t3u_mode", {31'd0, cce_mode_o}, 32'd0);

        // Empty mask: commit with no sync at all.
        bs = m_sent;
        start_mode(1'b1, 8'h00);
        cyc(2);
        check("t3_m0_stall_c2", {31'd0, stall}, 32'd1);
        cyc(1);
        check("t3_m0_stall_c3", {31'd0, stall}, 32'd0);
        check("t3_m0_mode", {31'd0, cce_mode_o}, 32'd1);
        check("t3_m0_sent", m_sent - bs, 32'd0);

        // Request flips back to uncached while acks are pending.
        start_mode(1'b0, 8'h00);
        wait_release("t4pre", n);
        ack_en = 0;
        bs = m_sent; ba = m_acked;
        start_mode(1'b1, 8'h0F);
        n = 0;
        while (m_sent - bs < 4 && n < 50) begin
            cyc(1);
            n++;
        end
        check("t4_all_sent", m_sent - bs, 32'd4);
        cfg_mode = 1'b0;
        forbid_normal = 1;
        ack_en = 1;
        wait_release("t4", n);
        check("t4_mode", {31'd0, cce_mode_o}, 32'd0);
        check("t4_acked", m_acked - ba, 32'd4);
        check("t4_q_empty", exp_q.size(), 32'd0);
        forbid_normal = 0;

        // Backpressure: header held, pointer parked on LCE 1.
        hdr_ready = 1'b0;
        bs = m_sent;
        start_mode(1'b1, 8'h12);
        n = 0;
        while (!hdr_v && n < 20) begin
            cyc(1);
            n++;
        end
        check("t5_v_seen", {31'd0, hdr_v}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            check("t5_v_hold", {31'd0, hdr_v}, 32'd1);
            check("t5_dst_hold", {28'd0, hdr[7:4]}, 32'd1);
        end
        check("t5_none_sent", m_sent - bs, 32'd0);
        hdr_ready = 1'b1;
        wait_release("t5", n);
        check("t5_sent", m_sent - bs, 32'd2);
        check("t5_mode", {31'd0, cce_mode_o}, 32'd1);

`ifdef BP_CCE_SYNC_TIMEOUT_EN
        // Withheld ack: error appears after 16 waiting cycles and sticks.
        start_mode(1'b0, 8'h00);
        wait_release("t6pre", n);
        check("t6_err_clean", {31'd0, sync_error}, 32'd0);
        ack_en = 0;
        bs = m_sent;
        start_mode(1'b1, 8'h01);
        n = 0;
        while (m_sent == bs && n < 20) begin
            cyc(1);
            n++;
        end
        check("t6_sent", m_sent - bs, 32'd1);
        check("t6_err_w1", {31'd0, sync_error}, 32'd0);
        for (int k = 2; k <= 16; k++) begin
            cyc(1);
            check("t6_err_low", {31'd0, sync_error}, 32'd0);
        end
        cyc(1);
        check("t6_err_rise", {31'd0, sync_error}, 32'd1);
        cyc(4);
        check("t6_err_sticky", {31'd0, sync_error}, 32'd1);
        ack_en = 1;
        wait_release("t6", n);
        check("t6_err_after", {31'd0, sync_error}, 32'd1);
        check("t6_mode", {31'd0, cce_mode_o}, 32'd1);
`endif

        // Reset mid-transition returns everything to reset values at once.
        start_mode(1'b0, 8'h00);
        cyc(1);
        check("t7_stall_pre", {31'd0, stall}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("t7_stall", {31'd0, stall}, 32'd0);
        check("t7_busy", {31'd0, busy}, 32'd0);
        check("t7_mode", {31'd0, cce_mode_o}, 32'd0);
        check("t7_v", {31'd0, hdr_v}, 32'd0);
        check("t7_err", {31'd0, sync_error}, 32'd0);
        exp_q.delete();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bp_cce_hybrid_sync_ctrl.md
# bp_cce_hybrid_sync_ctrl

Global mode-transition controller for the hybrid CCE, generalising the single-step sync controller. It tracks the config-bus CCE mode and drains the CCE pipelines before every change. On entry to normal mode it issues header-only sync commands to a runtime-selectable subset of LCEs, keeping a bounded window of syncs outstanding. Mode requests that change mid-transition are coalesced, not lost. It sits beside the CCE request/uncached/coherent pipes and drives the shared LCE command output arbiter.

## Interface
- bp_params_p, e_bp_default_cfg: supplies num_lce_p, cce_id_width_p, lce_id_width_p, paddr_width_p, lce_assoc_p.
- lce_data_width_p, dword_width_gp: LCE command data width; this block never sends data.
- sync_window_p, 4: maximum number of sync commands sent but not yet acked; legal range 1..num_lce_p.
- timeout_cycles_p, 4096: watchdog limit; used only when BP_CCE_SYNC_TIMEOUT_EN is defined.
- clk_i, in, 1: the single clock.
- reset_n_i, in, 1: asynchronous, active-low reset.
- cfg_bus_i, in, cfg_bus_width_lp: config bus; uses the cce_mode and cce_id fields.
- sync_mask_i, in, num_lce_p: bit i=1 means LCE i receives a sync. Sampled when draining completes.
- lce_cmd_header_o, out, lce_cmd_msg_header_width_lp: sync command header.
- lce_cmd_header_v_o, in/out: header valid (out) with lce_cmd_header_ready_and_i (in) as its ready; ready&valid handshake.
- lce_cmd_has_data_o, lce_cmd_data_o, lce_cmd_data_v_o, lce_cmd_last_o, out: constant 0.
- lce_cmd_data_ready_and_i, in, 1: unused.
- sync_yumi_i, in, 1: one sync ack consumed by the LCE response pipe.
- cce_mode_o, out, bp_cce_mode_e: committed mode.
- cce_id_o, out, cce_id_width_p: cfg_bus cce_id, passed straight through.
- drain_then_stall_o, out, 1: registered stall request to the CCE pipes.
- busy_o, out, 1: 1 whenever the FSM is not in e_ready.
- req_empty_i, uc_pipe_empty_i, coh_pipe_empty_i, mem_credits_full_i, in, 1 each: drain status inputs.
- sync_error_o, out, 1: sticky watchdog error; present only with BP_CCE_SYNC_TIMEOUT_EN.

## Operation
- Mode request is level-based: a request exists while cfg cce_mode != cce_mode_o.
- Drain is complete when drain_then_stall_o & req_empty_i & uc_pipe_empty_i & coh_pipe_empty_i & mem_credits_full_i.
- Internal state: target mode register tgt_r, mask register mask_r, send pointer ptr_r, sent counter, acked counter. The outstanding count is sent − acked; counters are clog2(num_lce_p+1) bits wide.
- FSM transitions:
  - e_ready → e_wait_drain on a request. In the same cycle: set drain_then_stall, capture tgt_r.
  - e_wait_drain, on drain complete: recapture tgt_r from cfg. If tgt_r = uncached, go to e_commit. If normal, capture mask_r, clear the counters, set ptr_r to the lowest set mask bit, and go to e_send_sync. If the mask is all-zero, go directly to e_commit.
  - e_send_sync: assert v_o when outstanding < sync_window_p. Header fields:
    - msg_type = e_bedrock_cmd_sync
    - src_id = cce_id
    - dst_id = ptr_r, zero-extended
  - On each handshake, advance ptr_r to the next set mask bit (priority encode of the bits above ptr_r). After the last set bit is sent, go to e_wait_ack.
  - e_wait_ack: when acked == sent, go to e_commit.
  - e_commit:
    - If cfg mode == tgt_r: enable the mode register, clear drain_then_stall, go to e_ready.
    - Otherwise: stay stalled and return to e_wait_drain with the pipes already drained.
- sync_yumi_i increments acked in any state. An ack received while in e_ready or e_wait_drain is a protocol error; the ack is still counted, and an assertion is required to fire.
- Simultaneous send and ack in one cycle: outstanding is unchanged.

## Timing
- Reset values: cce_mode_o = e_cce_mode_uncached; drain_then_stall_o, busy_o, v_o, sync_error_o = 0; FSM in e_ready; counters 0.
- drain_then_stall_o rises 1 cycle after the request is detected. It falls the cycle after e_commit.
- cce_mode_o updates in the same cycle drain_then_stall_o falls.
- Minimum uncached transition: 3 cycles from request to release, when the pipes are already empty.
- lce_cmd_header_v_o never depends combinationally on ready; at most one sync per cycle.
- If reset is asserted mid-transition, everything returns to reset values asynchronously and any in-flight syncs are abandoned. The system must reset the LCEs together with this block.

## Configuration
- BP_CCE_SYNC_TIMEOUT_EN defined:
  - A cycle counter clears on every handshake or ack and counts while in e_send_sync or e_wait_ack.
  - Reaching timeout_cycles_p sets sync_error_o, which is sticky until reset.
  - The FSM is not aborted.
- Not defined: the counter and the sync_error_o port are absent.

## Structure
- Shared package bp_me_pkg holds:
  - the state enum bp_cce_hybrid_sync_state_e
  - the drain-complete predicate as a function
- Sub-module bp_cce_sync_mask_walker holds mask_r, ptr_r and the next-set-bit priority encoder, with outputs valid/dst/last.
- Counters use bsg_counter_clear_up_down style logic adapted to asynchronous reset.

## Test plan
- Uncached → normal, num_lce_p=8, full mask, window 4, ready=1:
  - 4 syncs are sent to dst 0..3, then sending stalls until acks arrive.
  - After all 8 acks: cce_mode_o = normal and the stall clears.
- Mask 8'b1010_0100: exactly 3 syncs, to dst 2, 5, 7; commit follows the 3rd ack.
- Mask 0: commit with no lce_cmd_header_v_o pulse, 3 cycles after drain complete.
- cfg mode toggles normal → uncached during e_wait_ack: after the acks, the FSM re-enters e_wait_drain and commits uncached. cce_mode_o never shows normal.
- Backpressure: with ready held low for 10 cycles, the header stays stable and ptr_r does not advance.
- With the macro and timeout_cycles_p=16, withhold acks: sync_error_o rises on the 16th waiting cycle and stays high.
